// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcode, ALU-op, SP-control and condition encodings plus the control bundle
package cpu_pkg;

    localparam logic [3:0] OP_LOAD   = 4'b1000;
    localparam logic [3:0] OP_STORE  = 4'b1001;
    localparam logic [3:0] OP_BRC    = 4'b1010;
    localparam logic [3:0] OP_JUMP   = 4'b1011;
    localparam logic [3:0] OP_PUSH   = 4'b1100;
    localparam logic [3:0] OP_POP    = 4'b1101;
    localparam logic [3:0] OP_CALL   = 4'b1110;
    localparam logic [3:0] OP_MISC   = 4'b1111;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_XOR   = 3'b100;
    localparam logic [2:0] ALU_NOT   = 3'b101;
    localparam logic [2:0] ALU_SHL   = 3'b110;
    localparam logic [2:0] ALU_SHR   = 3'b111;

    localparam logic [1:0] SP_HOLD   = 2'b00;
    localparam logic [1:0] SP_PUSH   = 2'b01;
    localparam logic [1:0] SP_POP    = 2'b10;

    localparam logic [1:0] COND_Z    = 2'b00;
    localparam logic [1:0] COND_NZ   = 2'b01;
    localparam logic [1:0] COND_C    = 2'b10;
    localparam logic [1:0] COND_N    = 2'b11;

    localparam logic [1:0] MISC_NOP  = 2'b00;
    localparam logic [1:0] MISC_HALT = 2'b01;
    localparam logic [1:0] MISC_RET  = 2'b10;
    localparam logic [1:0] MISC_NOP3 = 2'b11;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       mem_write;
        logic       branch;
        logic       reg_load;
        logic [1:0] sp_ctl;
        logic       push_pc;
        logic       ret;
        logic       is_cond;
        logic       is_load;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

    typedef enum logic {ST_RUN, ST_HALTED} state_t;

endpackage

// File: rtl/cpu_controller.sv
// cpu_controller: combinational instruction decode with a sticky halt flag
//   clk, reset          : clock and synchronous active-high reset (reset also zeroes outputs)
//   ir_1, ir_2, ir_3    : opcode, sub-field (condition / misc function), reserved field
//   aluOp .. intisLoad  : datapath control outputs, all 0 while reset or halted
module cpu_controller
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] ir_1,
    input  logic [1:0] ir_2,
    input  logic [1:0] ir_3,
    output logic [2:0] aluOp,
    output logic       memReadWrite,
    output logic       branch,
    output logic       regLoad,
    output logic [1:0] muxPP,
    output logic       muxpush,
    output logic       muxreturn,
    output logic       intisCond,
    output logic       intisLoad
);
    state_t state, state_next;
    ctrl_t  dec, ctrl;
    logic   unused_ir3;

    assign unused_ir3 = ^ir_3;

    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_RUN;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (state == ST_RUN && ir_1 == OP_MISC && ir_2 == MISC_HALT)
            state_next = ST_HALTED;
    end

    always_comb begin
        dec = CTRL_IDLE;
        if (!ir_1[3]) begin
            dec.alu_op   = ir_1[2:0];
            dec.reg_load = 1'b1;
        end else begin
            case (ir_1)
                OP_LOAD: begin
                    dec.alu_op   = ALU_ADD;
                    dec.reg_load = 1'b1;
                    dec.is_load  = 1'b1;
                end
                OP_STORE: begin
                    dec.alu_op    = ALU_ADD;
                    dec.mem_write = 1'b1;
                end
                // condition selected by ir_2 is resolved in the datapath
                OP_BRC: begin
                    dec.alu_op  = ALU_ADD;
                    dec.branch  = 1'b1;
                    dec.is_cond = 1'b1;
                end
                OP_JUMP:
                    dec.branch = 1'b1;
                OP_PUSH: begin
                    dec.sp_ctl    = SP_PUSH;
                    dec.mem_write = 1'b1;
                end
                OP_POP: begin
                    dec.sp_ctl   = SP_POP;
                    dec.reg_load = 1'b1;
                    dec.is_load  = 1'b1;
                end
                // return address PC+1 is pushed in the same cycle as the jump
                OP_CALL: begin
                    dec.sp_ctl    = SP_PUSH;
                    dec.mem_write = 1'b1;
                    dec.push_pc   = 1'b1;
                    dec.branch    = 1'b1;
                end
                // HALT and both NOPs decode to idle; HALT acts only through the state flop
                OP_MISC:
                    if (ir_2 == MISC_RET) begin
                        dec.sp_ctl = SP_POP;
                        dec.ret    = 1'b1;
                        dec.branch = 1'b1;
                    end
                default: ;
            endcase
        end
    end

    assign ctrl = (reset || state == ST_HALTED) ? CTRL_IDLE : dec;

    assign aluOp        = ctrl.alu_op;
    assign memReadWrite = ctrl.mem_write;
    assign branch       = ctrl.branch;
    assign regLoad      = ctrl.reg_load;
    assign muxPP        = ctrl.sp_ctl;
    assign muxpush      = ctrl.push_pc;
    assign muxreturn    = ctrl.ret;
    assign intisCond    = ctrl.is_cond;
    assign intisLoad    = ctrl.is_load;

endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller: vector table, halt/reset sequences and random stimulus against a table model
module tb_cpu_controller;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] ir_1 = 4'd0;
    logic [1:0] ir_2 = 2'd0;
    logic [1:0] ir_3 = 2'd0;
    logic [2:0] aluOp;
    logic       memReadWrite, branch, regLoad, muxpush, muxreturn, intisCond, intisLoad;
    logic [1:0] muxPP;

    int checks = 0;
    int errors = 0;
    bit m_halted = 1'b0;

    always #5 clk = ~clk;

    cpu_controller dut (
        .clk(clk), .reset(reset), .ir_1(ir_1), .ir_2(ir_2), .ir_3(ir_3),
        .aluOp(aluOp), .memReadWrite(memReadWrite), .branch(branch), .regLoad(regLoad),
        .muxPP(muxPP), .muxpush(muxpush), .muxreturn(muxreturn),
        .intisCond(intisCond), .intisLoad(intisLoad)
    );

    // packed as {aluOp, memReadWrite, branch, regLoad, muxPP, muxpush, muxreturn, intisCond, intisLoad}
    function automatic logic [11:0] pk(input logic [2:0] alu, input logic mw, input logic br,
                                       input logic rl, input logic [1:0] pp, input logic pu,
                                       input logic rt, input logic ic, input logic il);
        return {alu, mw, br, rl, pp, pu, rt, ic, il};
    endfunction

    // spec rows: opcode row table for 1000..1110, misc row table by ir_2
    logic [11:0] op_row [8];
    logic [11:0] misc_row [4];

    function automatic logic [11:0] model(input logic rst, input logic halted,
                                          input logic [3:0] op, input logic [1:0] sub);
        if (rst || halted) return 12'd0;
        if (op < 4'd8) return pk(op[2:0], 0, 0, 1, 2'b00, 0, 0, 0, 0);
        if (op == 4'hF) return misc_row[sub];
        return op_row[op - 4'd8];
    endfunction

    typedef struct {
        logic        rst;
        logic [3:0]  op;
        logic [1:0]  sub;
        logic [1:0]  rsv;
        logic [11:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic cyc(input logic rst, input logic [3:0] op, input logic [1:0] sub,
                       input logic [1:0] rsv, input logic [11:0] exp, input string name);
        logic [11:0] act;
        reset = rst; ir_1 = op; ir_2 = sub; ir_3 = rsv;
        @(negedge clk);
        act = {aluOp, memReadWrite, branch, regLoad, muxPP, muxpush, muxreturn, intisCond, intisLoad};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: ir=%b/%b/%b reset=%b got %b expected %b", name, op, sub, rsv, rst, act, exp);
        end
        @(posedge clk);
        m_halted = rst ? 1'b0 : (m_halted || (op == 4'hF && sub == 2'b01));
        #1;
    endtask

    initial begin
        op_row[0] = pk(3'b000, 0, 0, 1, 2'b00, 0, 0, 0, 1);
        op_row[1] = pk(3'b000, 1, 0, 0, 2'b00, 0, 0, 0, 0);
        op_row[2] = pk(3'b000, 0, 1, 0, 2'b00, 0, 0, 1, 0);
        op_row[3] = pk(3'b000, 0, 1, 0, 2'b00, 0, 0, 0, 0);
        op_row[4] = pk(3'b000, 1, 0, 0, 2'b01, 0, 0, 0, 0);
        op_row[5] = pk(3'b000, 0, 0, 1, 2'b10, 0, 0, 0, 1);
        op_row[6] = pk(3'b000, 1, 1, 0, 2'b01, 1, 0, 0, 0);
        misc_row[0] = 12'd0;
        misc_row[1] = 12'd0;
        misc_row[2] = pk(3'b000, 0, 1, 0, 2'b10, 0, 1, 0, 0);
        misc_row[3] = 12'd0;

        vecs.push_back('{1, 4'b1011, 2'b00, 2'b00, 12'd0, "reset_jump"});
        vecs.push_back('{1, 4'b1111, 2'b01, 2'b00, 12'd0, "reset_halt"});
        vecs.push_back('{0, 4'b1111, 2'b10, 2'b11, pk(0, 0, 1, 0, 2'b10, 0, 1, 0, 0), "ret"});
        vecs.push_back('{0, 4'b1001, 2'b00, 2'b01, pk(0, 1, 0, 0, 2'b00, 0, 0, 0, 0), "store"});
        vecs.push_back('{0, 4'b1001, 2'b00, 2'b10, pk(0, 1, 0, 0, 2'b00, 0, 0, 0, 0), "store_ir3"});
        vecs.push_back('{0, 4'b0111, 2'b10, 2'b00, pk(3'b111, 0, 0, 1, 2'b00, 0, 0, 0, 0), "shr"});
        vecs.push_back('{0, 4'b1111, 2'b00, 2'b10, 12'd0, "nop0"});
        vecs.push_back('{0, 4'b1111, 2'b11, 2'b01, 12'd0, "nop3"});
        vecs.push_back('{0, 4'b1010, 2'b10, 2'b00, pk(0, 0, 1, 0, 2'b00, 0, 0, 1, 0), "brc"});
        vecs.push_back('{0, 4'b1110, 2'b00, 2'b00, pk(0, 1, 1, 0, 2'b01, 1, 0, 0, 0), "call"});
        vecs.push_back('{0, 4'b1000, 2'b00, 2'b00, pk(0, 0, 0, 1, 2'b00, 0, 0, 0, 1), "load"});
        vecs.push_back('{0, 4'b1011, 2'b01, 2'b00, pk(0, 0, 1, 0, 2'b00, 0, 0, 0, 0), "jump"});
        vecs.push_back('{0, 4'b1100, 2'b00, 2'b00, pk(0, 1, 0, 0, 2'b01, 0, 0, 0, 0), "push"});
        vecs.push_back('{0, 4'b1101, 2'b00, 2'b00, pk(0, 0, 0, 1, 2'b10, 0, 0, 0, 1), "pop"});

        foreach (vecs[i])
            cyc(vecs[i].rst, vecs[i].op, vecs[i].sub, vecs[i].rsv, vecs[i].exp, vecs[i].name);

        for (int i = 0; i < 8; i++) begin
            logic [3:0] op;
            op = 4'(i);
            cyc(0, op, 2'(i), 2'(i + 1), pk(op[2:0], 0, 0, 1, 2'b00, 0, 0, 0, 0), "alu_sweep");
        end

        cyc(0, 4'b1111, 2'b01, 2'b00, 12'd0, "halt_cycle");
        cyc(0, 4'b1011, 2'b00, 2'b00, 12'd0, "halted_jump");
        cyc(0, 4'b1110, 2'b00, 2'b00, 12'd0, "halted_call");
        cyc(0, 4'b0011, 2'b00, 2'b00, 12'd0, "halted_alu");
        cyc(1, 4'b1011, 2'b00, 2'b00, 12'd0, "reset_mid_halt");
        cyc(0, 4'b1011, 2'b00, 2'b00, pk(0, 0, 1, 0, 2'b00, 0, 0, 0, 0), "jump_after_reset");
        cyc(0, 4'b1111, 2'b01, 2'b00, 12'd0, "halt_again");
        cyc(1, 4'b1111, 2'b01, 2'b00, 12'd0, "reset_with_halt");
        cyc(0, 4'b1101, 2'b00, 2'b00, pk(0, 0, 0, 1, 2'b10, 0, 0, 0, 1), "pop_after_reset");

        for (int i = 0; i < 400; i++) begin
            logic       rst;
            logic [3:0] op;
            logic [1:0] sub, rsv;
            rst = ($urandom_range(0, 15) == 0);
            op  = 4'($urandom);
            sub = 2'($urandom);
            rsv = 2'($urandom);
            cyc(rst, op, sub, rsv, model(rst, m_halted, op, sub), "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
